// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped peripherals: default addresses,
// status word bit positions and the UART transmitter state encodings.
package mmio_pkg;

  localparam logic [31:0] TxAddrDefault     = 32'h0000_0080;
  localparam logic [31:0] StatusAddrDefault = 32'h0000_0084;

  localparam int unsigned StatusBusyBit = 0;
  localparam int unsigned StatusFullBit = 1;
  localparam int unsigned StatusOvfBit  = 2;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Processor store bus shared by data memory and the memory-mapped peripherals.
interface mmio_uart_tx_if;

  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;

  modport master (output memwrite, output dataadr, output writedata);
  modport slave  (input  memwrite, input  dataadr, input  writedata);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy count; pushes while full and pops while
// empty are ignored. Head entry is visible on dout_o without a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: a store to TX_ADDR queues a byte, the
// status word reports busy/full/sticky overflow, and a store to STATUS_ADDR clears overflow.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] TX_ADDR      = TxAddrDefault,
  parameter logic [31:0] STATUS_ADDR  = StatusAddrDefault
) (
  input  logic                 clk,
  input  logic                 reset,
  mmio_uart_tx_if.slave        bus,
  output logic [31:0]          status,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

  logic [1:0]       state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ovf_q, ovf_d;

  logic                        store_tx, store_status, ovf_set, ovf_clr, bit_end;
  logic                        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]                  fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        unused_bits;

  assign unused_bits = ^{bus.writedata[31:8], fifo_count};

  assign store_tx     = bus.memwrite && (bus.dataadr == TX_ADDR);
  assign store_status = bus.memwrite && (bus.dataadr == STATUS_ADDR);
  // Full is sampled before the edge, so a same-edge pop never rescues the byte.
  assign fifo_push    = store_tx && !fifo_full;
  assign ovf_set      = store_tx && fifo_full;
  assign ovf_clr      = store_status && bus.writedata[0];
  assign ovf_d        = ovf_set || (ovf_q && !ovf_clr);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (fifo_push),
    .din_i   (bus.writedata[7:0]),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bit_end = (baud_q == BaudW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    if (state_q != StIdle) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = '0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level is decoded from next state so tx_q changes on the bit edge itself.
  always_comb begin
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx   = tx_q;
  assign busy = !fifo_empty || (state_q != StIdle);

  always_comb begin
    status                = '0;
    status[StatusBusyBit] = busy;
    status[StatusFullBit] = fifo_full;
    status[StatusOvfBit]  = ovf_q;
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: stores queue expected bytes on a scoreboard, and a
// serial receiver on the tx line decodes frames and pops/compares them.
module tb_mmio_uart_tx;

  localparam int unsigned Clks  = 4;
  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] status;
  logic        tx;
  logic        busy;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .CLKS_PER_BIT (Clks),
    .FIFO_DEPTH   (Depth)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .status (status),
    .tx     (tx),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         ncyc = 0;

  bit         rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Receiver: samples on the falling clock edge, bit centres 2 cycles into each bit.
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (!reset) begin
        rx_active = 1'b0;
      end else if (!rx_active) begin
        if (tx === 1'b0) begin
          rx_active = 1'b1;
          rx_cnt    = 0;
          start_q.push_back(ncyc);
        end
      end else begin
        rx_cnt++;
        if (rx_cnt == 2) begin
          check_eq("rx_start_bit", tx, 0);
        end else if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt - 6) % 4 == 0) begin
          rx_sh = {tx, rx_sh[7:1]};
        end else if (rx_cnt == 38) begin
          check_eq("rx_stop_bit", tx, 1);
          check_eq("rx_sb_avail", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check_eq("rx_byte", rx_sh, exp_q.pop_front());
        end else if (rx_cnt == 39) begin
          rx_active = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; the next rising edge is the store edge.
  task automatic store(input logic [31:0] adr, input logic [31:0] data, input bit accept);
    bus.memwrite  = 1'b1;
    bus.dataadr   = adr;
    bus.writedata = data;
    if (accept) exp_q.push_back(data[7:0]);
    @(posedge clk);
    #1;
    bus.memwrite = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int i;
    i = 0;
    while (busy && i < max) begin
      tick(1);
      i++;
    end
    check_eq("drain_busy", busy, 0);
    tick(2);
    check_eq("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    reset         = 1'b0;
    bus.memwrite  = 1'b0;
    bus.dataadr   = '0;
    bus.writedata = '0;
    #12;
    check_eq("rst_tx", tx, 1);
    check_eq("rst_status", status, 0);
    check_eq("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(2);

    // Single frame, latency and length
    store(32'h0000_0080, 32'h0000_0155, 1'b1);
    check_eq("t1_lat_hold", tx, 1);
    tick(1);
    check_eq("t1_lat_fall", tx, 0);
    check_eq("t1_busy", busy, 1);
    tick(39);
    check_eq("t1_stop_tx", tx, 1);
    check_eq("t1_busy_end", busy, 1);
    tick(1);
    check_eq("t1_idle_busy", busy, 0);
    check_eq("t1_idle_tx", tx, 1);
    wait_idle(10);

    // Five back-to-back stores from idle: contiguous frames, no overflow
    start_q.delete();
    for (int i = 0; i < 5; i++) store(32'h0000_0080, 32'h11 + i, 1'b1);
    check_eq("t2_status", status, 32'h3);
    wait_idle(300);
    check_eq("t2_frames", start_q.size(), 5);
    for (int i = 1; i < 5 && i < start_q.size(); i++)
      check_eq("t2_contig", start_q[i] - start_q[i-1], 40);

    // Six stores: the sixth is dropped, then overflow is cleared
    for (int i = 0; i < 6; i++) store(32'h0000_0080, 32'h21 + i, i < 5);
    check_eq("t3_ovf_status", status, 32'h7);
    store(32'h0000_0084, 32'h0000_0001, 1'b0);
    check_eq("t3_clr_status", status, 32'h3);
    wait_idle(300);
    check_eq("t3_idle_status", status, 0);

    // Neighbouring addresses are not decoded
    store(32'h0000_007C, 32'h0000_0033, 1'b0);
    store(32'h0000_0081, 32'h0000_0044, 1'b0);
    check_eq("t4_status", status, 0);
    tick(10);
    check_eq("t4_tx", tx, 1);
    check_eq("t4_status_late", status, 0);

    // Reset in the middle of data bit 3 (a zero bit), then a clean frame
    store(32'h0000_0080, 32'h0000_0052, 1'b0);
    tick(18);
    check_eq("t5_pre_tx", tx, 0);
    reset = 1'b0;
    #1;
    check_eq("t5_rst_tx", tx, 1);
    check_eq("t5_rst_status", status, 0);
    check_eq("t5_rst_busy", busy, 0);
    tick(3);
    check_eq("t5_hold_tx", tx, 1);
    reset = 1'b1;
    store(32'h0000_0080, 32'h0000_00A5, 1'b1);
    check_eq("t5_lat_hold", tx, 1);
    tick(1);
    check_eq("t5_lat_fall", tx, 0);
    wait_idle(100);

    // Store to a full FIFO on the edge that pops for the next frame
    for (int i = 0; i < 5; i++) store(32'h0000_0080, 32'h31 + i, 1'b1);
    tick(36);
    check_eq("t6_pre_status", status, 32'h3);
    store(32'h0000_0080, 32'h0000_0036, 1'b0);
    check_eq("t6_drop_status", status, 32'h5);
    check_eq("t6_next_start", tx, 0);
    store(32'h0000_0080, 32'h0000_0037, 1'b1);
    check_eq("t6_refill_status", status, 32'h7);
    store(32'h0000_0084, 32'h0000_0001, 1'b0);
    wait_idle(400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
